// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational execute-stage ALU between two requesters:
// port 0 (pipeline execute path) and port 1 (branch-resolution path).
// Each accepted operation takes two cycles. In the first cycle the operands
// are captured. In the second cycle they drive the ALU. The registered result
// then appears as a one-cycle pulse on the granted port.
//
// Handshake: a request transfers on the rising edge where reqN_valid and
// reqN_ready are both high. Ready is combinational from valid and state, and
// is never high outside IDLE or while rst is high. The requester holds
// valid/op/a/b stable until it sees ready. Responses have no backpressure:
// rspN_valid pulses for one cycle. rspN_data and rspN_err hold their value
// until the next response to the same port.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b       request handshake for port N (N = 0, 1)
//   rspN_valid/data/err           response pulse, result, illegal-op flag
//   alu_op, alu_a, alu_b, alu_out connection to the shared ALU
//   dbg_state                     current FSM state (0 = IDLE, 1 = EXEC)
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin between ports on contention
//                  undefined -> fixed priority, port 0 always wins
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    // Opcodes 0..4 are the ALU's legal set (add, sub, and, or, eq-mask).
    localparam logic [OP_W-1:0] LAST_LEGAL_OP = OP_W'(4);

    logic [0:0]        state;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              win_q;     // port that owns the in-flight op
    logic              pick;      // port to grant if anything is valid
    logic              take;      // a handshake happens this cycle
    logic              op_legal;
    logic [DATA_W-1:0] result;

`ifdef ALU_ARB_RR_EN
    logic last_q;                 // port granted most recently

    // On contention, favour the port that was not granted last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            pick = ~last_q;
        end else begin
            pick = ~req0_valid;
        end
    end

    // Resets to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= pick;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is idle.
    always_comb begin
        pick = ~req0_valid;
    end
`endif

    // rst is included so that ready stays low for the whole reset window.
    // This also covers the instant reset rises in the middle of a cycle.
    assign take       = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = take && !pick;
    assign req1_ready = take && pick;

    assign op_legal  = (op_q <= LAST_LEGAL_OP);
    assign dbg_state = state;

    // Illegal opcodes leave the ALU idle. Their response carries 0 data.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (state == EXEC && op_legal) begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
        end
    end

    assign result = op_legal ? alu_out : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            win_q      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        op_q  <= pick ? req1_op : req0_op;
                        a_q   <= pick ? req1_a : req0_a;
                        b_q   <= pick ? req1_b : req0_b;
                        win_q <= pick;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (win_q) begin
                        rsp1_valid <= 1'b1;
                        rsp1_data  <= result;
                        rsp1_err   <= ~op_legal;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_data  <= result;
                        rsp0_err   <= ~op_legal;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// It contains a transaction-level model of the arbiter and the ALU. The
// model decides which port is granted, when the ALU is driven and which
// response arrives when. A single process compares that model with the DUT
// on every cycle. Directed tests also carry hand-computed literal checks.
module tb_alu_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic              clk;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              rsp0_err, rsp1_err;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [0:0]        dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference ALU: add, sub, and, or, eq-mask. Anything else gives 0.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return (a == b) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    // Response record: {port, err, data}.
    logic [DATA_W+1:0] exp_q[$];
    int                due_q[$];
    int                m_next_free = 0;
    logic              m_last = 1'b1;
    int                m_alu_cyc = -1;
    logic [OP_W-1:0]   m_alu_op;
    logic [DATA_W-1:0] m_alu_a, m_alu_b;
    logic [DATA_W-1:0] m_data0 = '0, m_data1 = '0;
    logic              m_err0 = 1'b0, m_err1 = 1'b0;

    always @(negedge clk) begin
        logic              e_v0, e_v1, g0, g1, p, any, legal;
        logic [DATA_W+1:0] rec;
        logic [OP_W-1:0]   e_op, op;
        logic [DATA_W-1:0] e_a, e_b, a, b;
        if (rst) begin
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_data}, 0);
            check("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_data}, 0);
            check("rst_alu", {alu_op, alu_a, alu_b}, 0);
            exp_q.delete();
            due_q.delete();
            m_next_free = 0;
            m_last      = 1'b1;
            m_alu_cyc   = -1;
            m_data0 = '0; m_data1 = '0; m_err0 = 1'b0; m_err1 = 1'b0;
        end else begin
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                rec = exp_q.pop_front();
                void'(due_q.pop_front());
                if (rec[DATA_W+1]) begin
                    e_v1 = 1'b1; m_err1 = rec[DATA_W]; m_data1 = rec[DATA_W-1:0];
                end else begin
                    e_v0 = 1'b1; m_err0 = rec[DATA_W]; m_data0 = rec[DATA_W-1:0];
                end
            end
            e_op = '0; e_a = '0; e_b = '0;
            if (m_alu_cyc == cyc) begin
                e_op = m_alu_op; e_a = m_alu_a; e_b = m_alu_b;
            end
            // Grant decision from the arbitration rules.
            any = (cyc >= m_next_free) && (req0_valid || req1_valid);
`ifdef ALU_ARB_RR_EN
            p = (req0_valid && req1_valid) ? !m_last : !req0_valid;
`else
            p = !req0_valid;
`endif
            g0 = any && !p;
            g1 = any && p;
            check("ready0", req0_ready, g0);
            check("ready1", req1_ready, g1);
            check("rsp0_valid", rsp0_valid, e_v0);
            check("rsp1_valid", rsp1_valid, e_v1);
            check("rsp0_data", {rsp0_err, rsp0_data}, {m_err0, m_data0});
            check("rsp1_data", {rsp1_err, rsp1_data}, {m_err1, m_data1});
            check("alu_bus", {alu_op, alu_a, alu_b}, {e_op, e_a, e_b});
            if (any) begin
                op    = p ? req1_op : req0_op;
                a     = p ? req1_a : req0_a;
                b     = p ? req1_b : req0_b;
                legal = (op <= 5'd4);
                m_last      = p;
                m_next_free = cyc + 2;
                m_alu_cyc   = cyc + 1;
                m_alu_op = legal ? op : '0;
                m_alu_a  = legal ? a : '0;
                m_alu_b  = legal ? b : '0;
                exp_q.push_back({p, !legal, legal ? alu_fn(op, a, b) : {DATA_W{1'b0}}});
                due_q.push_back(cyc + 2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cnt0, cnt1;
        rst = 1'b1;
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        check("lit_rst_rsp0_data", rsp0_data, 0);
        check("lit_rst_ready0", req0_ready, 0);
        tick();
        rst = 1'b0;

        // Single op: 5 + 7 on port 0.
        drive0(1, 0, 32'd5, 32'd7);
        @(negedge clk);
        check("lit_single_ready0", req0_ready, 1);
        tick();
        drive0(0, 0, 0, 0);
        @(negedge clk);
        check("lit_single_alu", {alu_op, alu_a, alu_b}, {5'd0, 32'd5, 32'd7});
        tick();
        @(negedge clk);
        check("lit_single_rsp0", {rsp0_valid, rsp0_data}, {1'b1, 32'd12});
        check("lit_single_rsp1_valid", rsp1_valid, 0);
        tick();

        // Contention: both ports held valid for 8 cycles.
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                drive0(1, 5'd1, 32'd10, 32'd3);
                drive1(1, 5'd4, 32'd9, 32'd9);
            end
            if (i == 8) begin
                drive0(0, 0, 0, 0);
                drive1(0, 0, 0, 0);
            end
            @(negedge clk);
            cnt0 += int'(rsp0_valid);
            cnt1 += int'(rsp1_valid);
            tick();
        end
        check("lit_cont_rsp0_data", rsp0_data, 32'd7);
`ifdef ALU_ARB_RR_EN
        check("lit_cont_cnt0", cnt0, 2);
        check("lit_cont_cnt1", cnt1, 2);
        check("lit_cont_rsp1_data", rsp1_data, 32'hFFFF_FFFF);
`else
        check("lit_cont_cnt0", cnt0, 4);
        check("lit_cont_cnt1", cnt1, 0);
        check("lit_cont_rsp1_data", rsp1_data, 32'd0);
`endif

        // Illegal opcode on port 1.
        drive1(1, 5'd5, 32'd1, 32'd2);
        @(negedge clk);
        check("lit_ill_ready", {req0_ready, req1_ready}, 2'b01);
        tick();
        drive1(0, 0, 0, 0);
        @(negedge clk);
        check("lit_ill_alu", {alu_op, alu_a, alu_b}, 0);
        tick();
        @(negedge clk);
        check("lit_ill_rsp1", {rsp1_valid, rsp1_err, rsp1_data}, {1'b1, 1'b1, 32'd0});
        tick();

        // Back-to-back on port 0: AND, then OR accepted in the response cycle.
        drive0(1, 5'd2, 32'h0000_F0F0, 32'h0000_FF00);
        @(negedge clk);
        check("lit_b2b_ready_a", req0_ready, 1);
        tick();
        drive0(0, 0, 0, 0);
        @(negedge clk);
        tick();
        drive0(1, 5'd3, 32'h1, 32'h2);
        @(negedge clk);
        check("lit_b2b_rsp_a", {rsp0_valid, rsp0_data}, {1'b1, 32'h0000_F000});
        check("lit_b2b_ready_b", req0_ready, 1);
        tick();
        drive0(0, 0, 0, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("lit_b2b_rsp_b", {rsp0_valid, rsp0_data}, {1'b1, 32'h3});
        tick();

        // Reset during EXEC drops the op. Port 1 then runs normally.
        drive0(1, 5'd0, 32'd1, 32'd1);
        @(negedge clk);
        check("lit_rmid_ready0", req0_ready, 1);
        tick();
        rst = 1'b1;
        drive0(0, 0, 0, 0);
        @(negedge clk);
        check("lit_rmid_alu", {alu_op, alu_a, alu_b}, 0);
        check("lit_rmid_rsp0", {rsp0_valid, rsp0_err, rsp0_data}, 0);
        tick();
        tick();
        rst = 1'b0;
        drive1(1, 5'd0, 32'd100, 32'd23);
        cnt0 = 0;
        @(negedge clk);
        check("lit_rel_ready1", req1_ready, 1);
        tick();
        drive1(0, 0, 0, 0);
        @(negedge clk);
        cnt0 += int'(rsp0_valid);
        tick();
        @(negedge clk);
        cnt0 += int'(rsp0_valid);
        check("lit_rel_rsp1", {rsp1_valid, rsp1_err, rsp1_data}, {1'b1, 1'b0, 32'd123});
        tick();
        @(negedge clk);
        cnt0 += int'(rsp0_valid);
        tick();
        check("lit_rmid_no_rsp0", cnt0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
